// File: rtl/cnn_window_gen_pkg.sv
// Shared constants for the CNN sliding-window generator.
// Kernel one-hot codes, window geometry and FSM encodings.
package cnn_window_gen_pkg;

  localparam int KERNEL_SIZE = 3;
  localparam int WINDOW_SIZE = 9;
  localparam int KDIM        = 3;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [KERNEL_SIZE-1:0] K_2 = 3'b010;
  localparam logic [KERNEL_SIZE-1:0] K_3 = 3'b100;

  function automatic logic k_ok(
    input logic [KERNEL_SIZE-1:0] k
  );
    return (k == K_2) || (k == K_3);
  endfunction

  function automatic logic [1:0] phase_step(
    input logic [1:0] p,
    input logic [1:0] s
  );
    return (p == s - 2'd1) ? 2'd0 : p + 2'd1;
  endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One image row of 32-bit pixels for the window generator.
// Asynchronous read and synchronous write give read-before-write.
module cnn_line_buffer #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/cnn_window_gen.sv
// Raster pixel stream to strided Kh x Kw window stream.
// Optional stall_cycles output under WINGEN_STALL_CNT_EN.
module cnn_window_gen
  import cnn_window_gen_pkg::*;
#(
  parameter int MAX_WIDTH = 256,
  parameter int DIM_W     = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      conf_refresh,
  input  logic [DIM_W-1:0]          img_width,
  input  logic [DIM_W-1:0]          img_height,
  input  logic [KERNEL_SIZE-1:0]    kernel_height,
  input  logic [KERNEL_SIZE-1:0]    kernel_width,
  input  logic [1:0]                stride,
  input  logic                      pix_valid,
  input  logic [31:0]               pix_data,
  output logic                      pix_ready,
  output logic                      window_valid,
  output logic [WINDOW_SIZE*32-1:0] window,
  input  logic                      window_stall,
  output logic                      busy,
  output logic                      frame_done
`ifdef WINGEN_STALL_CNT_EN
  ,
  output logic [31:0]               stall_cycles
`endif
);

  localparam int AW = $clog2(MAX_WIDTH);
  localparam int WB = WINDOW_SIZE * 32;

  logic [1:0]       state_q, state_d;
  logic [DIM_W-1:0] w_q, w_d, h_q, h_d;
  logic [DIM_W-1:0] col_q, col_d, row_q, row_d;
  logic [1:0]       s_q, s_d, cph_q, cph_d, rph_q, rph_d;
  logic             kh3_q, kh3_d, kw3_q, kw3_d;
  logic             kok_q, kok_d;
  logic             valid_q, valid_d, done_q, done_d;
  logic [WB-1:0]    win_o_q, win_o_d, pack;
  logic [31:0]      win_q [KDIM][KDIM];
  logic [31:0]      nxt [KDIM][KDIM];
  logic [31:0]      col_in [KDIM];
  logic [31:0]      lb0_rd, lb1_rd;
  logic             accept, emit;
  logic             col_last, row_last, col_ge, row_ge;
  logic [DIM_W-1:0] kh_m1, kw_m1;

  assign pix_ready = (state_q == ST_RUN) & ~window_stall;
  assign accept    = pix_valid & pix_ready;

  assign kh_m1    = kh3_q ? DIM_W'(2) : DIM_W'(1);
  assign kw_m1    = kw3_q ? DIM_W'(2) : DIM_W'(1);
  assign col_last = col_q == w_q - 1'b1;
  assign row_last = row_q == h_q - 1'b1;
  assign col_ge   = col_q >= kw_m1;
  assign row_ge   = row_q >= kh_m1;

  assign emit = accept & kok_q & row_ge & col_ge
              & (cph_q == 2'd0) & (rph_q == 2'd0);

  cnn_line_buffer #(.DEPTH(MAX_WIDTH)) u_lb0 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q[AW-1:0]),
    .wdata_i (pix_data),
    .rdata_o (lb0_rd)
  );

  cnn_line_buffer #(.DEPTH(MAX_WIDTH)) u_lb1 (
    .clk     (clk),
    .we_i    (accept),
    .addr_i  (col_q[AW-1:0]),
    .wdata_i (lb0_rd),
    .rdata_o (lb1_rd)
  );

  // Rows held bottom-aligned: row 2 is always the live pixel
  assign col_in[0] = lb1_rd;
  assign col_in[1] = lb0_rd;
  assign col_in[2] = pix_data;

  always_comb begin
    for (int r = 0; r < KDIM; r++) begin
      for (int c = 0; c < KDIM; c++) nxt[r][c] = win_q[r][c];
      if (accept) begin
        nxt[r][0] = win_q[r][1];
        nxt[r][1] = win_q[r][2];
        nxt[r][2] = col_in[r];
      end
    end
  end

  always_comb begin
    pack = '0;
    unique case ({kh3_q, kw3_q})
      2'b11:
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++)
            pack[(r*3+c)*32 +: 32] = nxt[r][c];
      2'b01:
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 3; c++)
            pack[(r*3+c)*32 +: 32] = nxt[r+1][c];
      2'b10:
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 2; c++)
            pack[(r*2+c)*32 +: 32] = nxt[r][c+1];
      default:
        for (int r = 0; r < 2; r++)
          for (int c = 0; c < 2; c++)
            pack[(r*2+c)*32 +: 32] = nxt[r+1][c+1];
    endcase
  end

  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    h_d     = h_q;
    s_d     = s_q;
    kh3_d   = kh3_q;
    kw3_d   = kw3_q;
    kok_d   = kok_q;
    col_d   = col_q;
    row_d   = row_q;
    cph_d   = cph_q;
    rph_d   = rph_q;
    done_d  = 1'b0;
    unique case (1'b1)
      (state_q == ST_IDLE): begin
        if (conf_refresh) begin
          w_d     = img_width;
          h_d     = img_height;
          s_d     = (stride == 2'd0) ? 2'd1 : stride;
          kh3_d   = kernel_height == K_3;
          kw3_d   = kernel_width == K_3;
          kok_d   = k_ok(kernel_height) & k_ok(kernel_width);
          col_d   = '0;
          row_d   = '0;
          cph_d   = '0;
          rph_d   = '0;
          state_d = ST_RUN;
        end
      end
      (state_q == ST_RUN): begin
        if (accept) begin
          if (col_last) begin
            col_d = '0;
            cph_d = '0;
            row_d = row_q + 1'b1;
            if (row_ge) rph_d = phase_step(rph_q, s_q);
            if (row_last) state_d = ST_DRAIN;
          end else begin
            col_d = col_q + 1'b1;
            if (col_ge) cph_d = phase_step(cph_q, s_q);
          end
        end
      end
      default: begin
        if (!valid_q || !window_stall) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  assign valid_d = window_stall ? valid_q : emit;
  assign win_o_d = emit ? pack : win_o_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      s_q     <= '0;
      kh3_q   <= 1'b0;
      kw3_q   <= 1'b0;
      kok_q   <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      cph_q   <= '0;
      rph_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      win_o_q <= '0;
      for (int r = 0; r < KDIM; r++)
        for (int c = 0; c < KDIM; c++) win_q[r][c] <= '0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      h_q     <= h_d;
      s_q     <= s_d;
      kh3_q   <= kh3_d;
      kw3_q   <= kw3_d;
      kok_q   <= kok_d;
      col_q   <= col_d;
      row_q   <= row_d;
      cph_q   <= cph_d;
      rph_q   <= rph_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      win_o_q <= win_o_d;
      win_q   <= nxt;
    end
  end

`ifdef WINGEN_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (state_q == ST_IDLE && conf_refresh) begin
      stall_cnt_q <= '0;
    end else if (valid_q && window_stall && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cycles = stall_cnt_q;
`endif

  assign window_valid = valid_q;
  assign window       = win_o_q;
  assign busy         = state_q != ST_IDLE;
  assign frame_done   = done_q;

endmodule

// File: tb/tb_cnn_window_gen.sv
// Scoreboard bench for cnn_window_gen with a direct window model.
// Define WINGEN_STALL_CNT_EN to also check stall_cycles.
module tb_cnn_window_gen;
  import cnn_window_gen_pkg::*;

  localparam int DW = 10;
  localparam int WB = WINDOW_SIZE * 32;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic                   conf_refresh = 1'b0;
  logic [DW-1:0]          img_width = '0;
  logic [DW-1:0]          img_height = '0;
  logic [KERNEL_SIZE-1:0] kernel_height = '0;
  logic [KERNEL_SIZE-1:0] kernel_width = '0;
  logic [1:0]             stride = '0;
  logic                   pix_valid = 1'b0;
  logic [31:0]            pix_data = '0;
  logic                   pix_ready;
  logic                   window_valid;
  logic [WB-1:0]          window;
  logic                   window_stall = 1'b0;
  logic                   busy;
  logic                   frame_done;
`ifdef WINGEN_STALL_CNT_EN
  logic [31:0]            stall_cycles;
`endif

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int stall_mode = 0;
  int hold_len = 5;
  int hold_left = 0;
  bit hold_done = 1'b0;
  logic [WB-1:0] expq [$];
  logic [31:0]   img [0:4095];

  cnn_window_gen dut (
    .clk           (clk),
    .rst           (rst),
    .conf_refresh  (conf_refresh),
    .img_width     (img_width),
    .img_height    (img_height),
    .kernel_height (kernel_height),
    .kernel_width  (kernel_width),
    .stride        (stride),
    .pix_valid     (pix_valid),
    .pix_data      (pix_data),
    .pix_ready     (pix_ready),
    .window_valid  (window_valid),
    .window        (window),
    .window_stall  (window_stall),
    .busy          (busy),
    .frame_done    (frame_done)
`ifdef WINGEN_STALL_CNT_EN
    ,
    .stall_cycles  (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [WB-1:0] act,
                     input logic [WB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: a window is consumed when valid and not stalled
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) done_cnt++;
      if (window_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_window act=%0h", window);
        end else begin
          chk("window", window, expq[0]);
          if (window_stall) chk("pix_ready_stalled", WB'(pix_ready), '0);
          else void'(expq.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (stall_mode == 1) begin
      window_stall = ($urandom_range(0, 3) == 0);
    end else if (stall_mode == 2) begin
      if (hold_left > 0) begin
        window_stall = 1'b1;
        hold_left--;
      end else if (!hold_done && window_valid) begin
        window_stall = 1'b1;
        hold_left = hold_len - 1;
        hold_done = 1'b1;
      end else begin
        window_stall = 1'b0;
      end
    end else begin
      window_stall = 1'b0;
    end
  end

  function automatic int kdec(input logic [2:0] c);
    if (c == 3'b010) return 2;
    if (c == 3'b100) return 3;
    return 0;
  endfunction

  task automatic push_model(input int w, input int h, input logic [2:0] khc,
                            input logic [2:0] kwc, input int s);
    int kh;
    int kw;
    int se;
    logic [WB-1:0] e;
    kh = kdec(khc);
    kw = kdec(kwc);
    se = (s == 0) ? 1 : s;
    if (kh == 0 || kw == 0) return;
    for (int y = 0; y + kh <= h; y += se)
      for (int x = 0; x + kw <= w; x += se) begin
        e = '0;
        for (int r = 0; r < kh; r++)
          for (int c = 0; c < kw; c++)
            e[(r*kw+c)*32 +: 32] = img[(y+r)*w + x + c];
        expq.push_back(e);
      end
  endtask

  task automatic pulse_conf(input int w, input int h, input logic [2:0] khc,
                            input logic [2:0] kwc, input int s);
    img_width     = DW'(w);
    img_height    = DW'(h);
    kernel_height = khc;
    kernel_width  = kwc;
    stride        = 2'(s);
    conf_refresh  = 1'b1;
    @(posedge clk);
    #1;
    conf_refresh  = 1'b0;
  endtask

  task automatic fill_img(input int n, input bit rnd);
    for (int i = 0; i < n; i++) img[i] = rnd ? $urandom : 32'(i);
  endtask

  task automatic send_pixels(input int first, input int last, input bit gaps);
    int i;
    int budget;
    bit ok;
    i = first;
    budget = 0;
    while (i < last && budget < 20000) begin
      pix_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      pix_data  = img[i];
      @(negedge clk);
      ok = pix_valid && pix_ready;
      @(posedge clk);
      #1;
      if (ok) i++;
      budget++;
    end
    pix_valid = 1'b0;
    if (i < last) begin
      checks++;
      errors++;
      $display("FAIL pixel_timeout act=%0d exp=%0d", i, last);
    end
  endtask

  task automatic finish_frame();
    int n;
    int d0;
    bit seen;
    n = 0;
    d0 = done_cnt;
    seen = 1'b0;
    while (n < 2000 && !seen) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
      n++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout act=0 exp=1");
    end
    @(negedge clk);
    chk("frame_done_pulse", WB'(frame_done), '0);
    chk("frame_done_count", WB'(done_cnt - d0), WB'(1));
    chk("busy_idle", WB'(busy), '0);
    chk("queue_empty", WB'(expq.size()), '0);
  endtask

  task automatic run_frame(input int w, input int h, input logic [2:0] khc,
                           input logic [2:0] kwc, input int s,
                           input bit rnd, input bit gaps);
    fill_img(w * h, rnd);
    push_model(w, h, khc, kwc, s);
    pulse_conf(w, h, khc, kwc, s);
    chk("busy_run", WB'(busy), WB'(1));
    send_pixels(0, w * h, gaps);
    finish_frame();
  endtask

  task automatic chk_reset_state();
    chk("rst_pix_ready", WB'(pix_ready), '0);
    chk("rst_window_valid", WB'(window_valid), '0);
    chk("rst_window", window, '0);
    chk("rst_busy", WB'(busy), '0);
    chk("rst_frame_done", WB'(frame_done), '0);
`ifdef WINGEN_STALL_CNT_EN
    chk("rst_stall_cycles", WB'(stall_cycles), '0);
`endif
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int h;
    logic [2:0] khc;
    logic [2:0] kwc;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 4x4, 2x2, stride 2, pixels 0..15
    run_frame(4, 4, 3'b010, 3'b010, 2, 1'b0, 1'b0);
    // 4x4, 3x3, stride 1; next conf lands right after frame_done
    run_frame(4, 4, 3'b100, 3'b100, 1, 1'b0, 1'b0);
    // smallest image, stride code 0 means 1
    run_frame(2, 2, 3'b010, 3'b010, 0, 1'b1, 1'b0);

    // five-cycle hold on a valid window
    stall_mode = 2;
    hold_len = 5;
    hold_done = 1'b0;
    run_frame(6, 5, 3'b100, 3'b010, 1, 1'b1, 1'b0);
    stall_mode = 0;

    // reset in the middle of row 2
    fill_img(16, 1'b0);
    push_model(4, 4, 3'b010, 3'b010, 2);
    pulse_conf(4, 4, 3'b010, 3'b010, 2);
    send_pixels(0, 10, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_reset_state();
    @(posedge clk);
    #1;
    rst = 1'b0;
    expq.delete();
    run_frame(4, 4, 3'b010, 3'b010, 2, 1'b0, 1'b0);

    // conf_refresh during RUN must be ignored
    fill_img(30, 1'b1);
    push_model(6, 5, 3'b100, 3'b100, 1);
    pulse_conf(6, 5, 3'b100, 3'b100, 1);
    send_pixels(0, 11, 1'b0);
    pulse_conf(3, 3, 3'b010, 3'b010, 2);
    send_pixels(11, 30, 1'b0);
    finish_frame();

    // invalid kernel code: frame consumed, no windows
    run_frame(5, 4, 3'b011, 3'b010, 1, 1'b1, 1'b0);

    // full-width rows exercise the line-buffer depth
    stall_mode = 1;
    run_frame(256, 3, 3'b100, 3'b100, 3, 1'b1, 1'b1);

    for (int k = 0; k < 8; k++) begin
      w = $urandom_range(3, 12);
      h = $urandom_range(3, 8);
      khc = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b100;
      kwc = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'b100;
      run_frame(w, h, khc, kwc, $urandom_range(0, 3), 1'b1, 1'b1);
    end
    stall_mode = 0;

`ifdef WINGEN_STALL_CNT_EN
    stall_mode = 2;
    hold_len = 7;
    hold_done = 1'b0;
    run_frame(4, 4, 3'b010, 3'b010, 2, 1'b1, 1'b0);
    stall_mode = 0;
    chk("stall_cycles_7", WB'(stall_cycles), WB'(7));
    fill_img(16, 1'b1);
    push_model(4, 4, 3'b010, 3'b010, 1);
    pulse_conf(4, 4, 3'b010, 3'b010, 1);
    chk("stall_cycles_clr", WB'(stall_cycles), '0);
    send_pixels(0, 16, 1'b0);
    finish_frame();
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
